hazard_branch_tracker: RTL and testbench
========================================

Name: hazard_branch_tracker

Overview:
- Sequential pipeline-state tracker feeding the launch/NOP control of the 5-stage core.
- Shadows stages 3 (execute), 4 (memory) and 5 (writeback) with valid, destination-register and branch flags.
- From that state and the decode-stage fields, produces is_hazzard, is_branch, is_branch_step_4 and nop_step_5 for the launch controller, and counts stall and bubble cycles.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- dec_valid  input  1  stage 2 holds a real instruction, not a NOP.
- dec_is_branch  input  1  stage-2 instruction is a branch or jump.
- dec_rs1  input  REG_ADDR_W  stage-2 source register 1.
- dec_rs2  input  REG_ADDR_W  stage-2 source register 2.
- dec_uses_rs1  input  1  rs1 is actually read.
- dec_uses_rs2  input  1  rs2 is actually read.
- dec_writes_rd  input  1  stage-2 instruction writes a register.
- dec_rd  input  REG_ADDR_W  stage-2 destination register.
- nop_step_3  input  1  from launch control: inject a bubble into stage 3 this cycle.
- is_hazzard  output  1  RAW hazard on the stage-2 instruction; stall fetch/decode.
- is_branch  output  1  a branch is in flight in stage 2, 3 or 4.
- is_branch_step_4  output  1  branch is in stage 4; target resolved, PC may load.
- nop_step_5  output  1  stage 5 holds a bubble.
- stall_cnt  output  CNT_W  cycles with is_hazzard=1.
- bubble_cnt  output  CNT_W  cycles in which a bubble entered stage 3.

Behaviour:
- Per-stage entry, kept for s3, s4 and s5: {valid, is_branch, writes_rd, rd}. A bubble is valid=0 with all other fields 0.
- Shift on every clock edge when reset=0. There is no enable; the pipeline never freezes past stage 2.
  - s5 <= s4.
  - s4 <= s3.
  - s3 <= bubble if (nop_step_3 | ~dec_valid), else {1, dec_is_branch, dec_writes_rd, dec_rd}.
- Hazard (combinational from registered state and dec inputs):
  - A match on stage k, k in {3,4,5}, is: sk.valid & sk.writes_rd & (sk.rd != 0) & ((dec_uses_rs1 & dec_rs1 == sk.rd) | (dec_uses_rs2 & dec_rs2 == sk.rd)).
  - is_hazzard = dec_valid & (match on any of stages 3, 4, 5). There is no forwarding.
  - Register 0 never hazards.
- is_branch = (dec_valid & dec_is_branch) | (s3.valid & s3.is_branch) | (s4.valid & s4.is_branch). Combinational.
- is_branch_step_4 = s4.valid & s4.is_branch. Combinational.
- nop_step_5 = ~s5.valid. Combinational.
- Hazard priority: a branch stalled in decode keeps is_branch=1 and is_hazzard=1 together. The launch controller resolves the priority; this block does not suppress either output.
- Counters:
  - stall_cnt increments on each edge where is_hazzard=1.
  - bubble_cnt increments on each edge where a bubble is loaded into s3.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset, synchronous, takes precedence over everything including the shift:
  - s3, s4 and s5 become bubbles.
  - Both counters become 0.
  - Resulting output values: is_hazzard=0 (with dec_valid=0), is_branch=0 (with dec_valid=0), is_branch_step_4=0, nop_step_5=1.
- Reset asserted mid-stream discards all in-flight state on that edge. A hazard present in that cycle is not counted.
- Latency: an instruction accepted into s3 at edge N appears in s4 at edge N+1 and in s5 at edge N+2. Its hazard shadow clears after edge N+3.

Test Plan:
- Reset: assert reset for 2 cycles with dec_valid=1 -> after release nop_step_5=1, is_branch_step_4=0, stall_cnt=0, bubble_cnt=0.
- RAW stall: issue "write r5" (dec_writes_rd=1, dec_rd=5), then decode "read r5" (rs1=5, uses_rs1=1) while the bench drives nop_step_3=is_hazzard -> is_hazzard=1 for exactly 3 cycles, then 0; stall_cnt=3, bubble_cnt=3.
- r0 write: issue "write r0", then "read r0" -> is_hazzard stays 0; stall_cnt=0.
- Branch walk: decode a branch with dec_valid=1, then dec_valid=0 -> is_branch=1 for 3 cycles; is_branch_step_4=1 only in the third; nop_step_5=0 in the fourth.
- Saturation: with CNT_W=4, hold a hazard for 20 cycles -> stall_cnt reaches 15 and stays 15.
- Mid-stream reset: a branch is in s3 and a writer is in s4; pulse reset for 1 cycle -> next cycle is_branch=0 (dec_valid=0), is_hazzard=0 for a dependent read, counters=0.

Source files
------------

// File: rtl/hazard_branch_tracker_if.sv
// rtl/hazard_branch_tracker_if.sv - decode-side fields, launch control and tracker outputs
interface hazard_branch_tracker_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  dec_valid;
    logic                  dec_is_branch;
    logic [REG_ADDR_W-1:0] dec_rs1;
    logic [REG_ADDR_W-1:0] dec_rs2;
    logic                  dec_uses_rs1;
    logic                  dec_uses_rs2;
    logic                  dec_writes_rd;
    logic [REG_ADDR_W-1:0] dec_rd;
    logic                  nop_step_3;
    logic                  is_hazzard;
    logic                  is_branch;
    logic                  is_branch_step_4;
    logic                  nop_step_5;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      bubble_cnt;

    modport master (
        output dec_valid, dec_is_branch, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
        output dec_writes_rd, dec_rd, nop_step_3,
        input  is_hazzard, is_branch, is_branch_step_4, nop_step_5, stall_cnt, bubble_cnt
    );

    modport slave (
        input  dec_valid, dec_is_branch, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
        input  dec_writes_rd, dec_rd, nop_step_3,
        output is_hazzard, is_branch, is_branch_step_4, nop_step_5, stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/hazard_branch_tracker.sv
// rtl/hazard_branch_tracker.sv - shadows execute/memory/writeback for hazard, branch and NOP control
module hazard_branch_tracker #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    hazard_branch_tracker_if.slave  bus
);
    typedef struct packed {
        logic                  valid;
        logic                  is_branch;
        logic                  writes_rd;
        logic [REG_ADDR_W-1:0] rd;
    } stage_t;

    stage_t           s3, s4, s5, s3_next;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt;
    logic             load_bubble;
    logic             hazard;

    // No forwarding: any live writer of a register the decode stage reads blocks it, r0 excepted.
    function automatic logic raw_match(
        input stage_t                s,
        input logic                  uses_rs1,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic                  uses_rs2,
        input logic [REG_ADDR_W-1:0] rs2
    );
        return s.valid & s.writes_rd & (s.rd != '0) &
               ((uses_rs1 & (rs1 == s.rd)) | (uses_rs2 & (rs2 == s.rd)));
    endfunction

    always_comb begin
        load_bubble = bus.nop_step_3 | ~bus.dec_valid;
        s3_next     = '0;
        if (!load_bubble) begin
            s3_next.valid     = 1'b1;
            s3_next.is_branch = bus.dec_is_branch;
            s3_next.writes_rd = bus.dec_writes_rd;
            s3_next.rd        = bus.dec_rd;
        end
        hazard = bus.dec_valid &
                 (raw_match(s3, bus.dec_uses_rs1, bus.dec_rs1, bus.dec_uses_rs2, bus.dec_rs2) |
                  raw_match(s4, bus.dec_uses_rs1, bus.dec_rs1, bus.dec_uses_rs2, bus.dec_rs2) |
                  raw_match(s5, bus.dec_uses_rs1, bus.dec_rs1, bus.dec_uses_rs2, bus.dec_rs2));
    end

    assign bus.is_hazzard       = hazard;
    assign bus.is_branch        = (bus.dec_valid & bus.dec_is_branch) |
                                  (s3.valid & s3.is_branch) | (s4.valid & s4.is_branch);
    assign bus.is_branch_step_4 = s4.valid & s4.is_branch;
    assign bus.nop_step_5       = ~s5.valid;
    assign bus.stall_cnt        = stall_cnt;
    assign bus.bubble_cnt       = bubble_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s3         <= '0;
            s4         <= '0;
            s5         <= '0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            s5 <= s4;
            s4 <= s3;
            s3 <= s3_next;
            if (hazard && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (load_bubble && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_branch_tracker.sv
// tb/tb_hazard_branch_tracker.sv - randomized and directed checks against an in-flight instruction model
module tb_hazard_branch_tracker;
    localparam int AW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_branch_tracker_if #(.REG_ADDR_W(AW), .CNT_W(CW)) bus ();

    hazard_branch_tracker #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Each accepted instruction is tracked with its age: 1 = execute, 2 = memory, 3 = writeback.
    typedef struct {
        bit br;
        bit wr;
        int rd;
        int age;
    } rec_t;

    rec_t q[$];
    int   m_stall, m_bubble;
    int   checks, errors;
    bit   exp_haz;
    int   d_haz, d_br, d_step4, d_nop5, d_stall, d_bubble;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit dv, input bit br, input int rs1, input int rs2,
                       input bit u1, input bit u2, input bit wr, input int rd,
                       input bit nop_follow, input bit nop_force);
        bit   e_br, e_s4, e_nop5, nop;
        rec_t nq[$];
        @(negedge clk);
        reset = rst;
        bus.dec_valid     = dv;
        bus.dec_is_branch = br;
        bus.dec_rs1       = AW'(rs1);
        bus.dec_rs2       = AW'(rs2);
        bus.dec_uses_rs1  = u1;
        bus.dec_uses_rs2  = u2;
        bus.dec_writes_rd = wr;
        bus.dec_rd        = AW'(rd);
        exp_haz = 1'b0;
        e_br    = dv & br;
        e_s4    = 1'b0;
        e_nop5  = 1'b1;
        foreach (q[i]) begin
            if (dv && q[i].wr && q[i].rd != 0 && ((u1 && rs1 == q[i].rd) || (u2 && rs2 == q[i].rd)))
                exp_haz = 1'b1;
            if (q[i].br && q[i].age <= 2) e_br = 1'b1;
            if (q[i].br && q[i].age == 2) e_s4 = 1'b1;
            if (q[i].age == 3) e_nop5 = 1'b0;
        end
        nop = nop_force | (nop_follow & exp_haz);
        bus.nop_step_3 = nop;
        #1;
        d_haz    = int'(bus.is_hazzard);
        d_br     = int'(bus.is_branch);
        d_step4  = int'(bus.is_branch_step_4);
        d_nop5   = int'(bus.nop_step_5);
        d_stall  = int'(bus.stall_cnt);
        d_bubble = int'(bus.bubble_cnt);
        check("is_hazzard", d_haz, int'(exp_haz));
        check("is_branch", d_br, int'(e_br));
        check("is_branch_step_4", d_step4, int'(e_s4));
        check("nop_step_5", d_nop5, int'(e_nop5));
        check("stall_cnt", d_stall, m_stall);
        check("bubble_cnt", d_bubble, m_bubble);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            if (exp_haz && m_stall < CMAX) m_stall++;
            foreach (q[i]) begin
                if (q[i].age < 3) begin
                    rec_t r = q[i];
                    r.age++;
                    nq.push_back(r);
                end
            end
            if (nop || !dv) begin
                if (m_bubble < CMAX) m_bubble++;
            end else begin
                nq.push_back('{br: br, wr: wr, rd: rd, age: 1});
            end
            q = nq;
        end
    endtask

    task automatic idle(input bit rst);
        cyc(rst, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic issue(input bit br, input bit wr, input int rd, input int rs1, input bit u1,
                         input bit nop_follow);
        cyc(1'b0, 1'b1, br, rs1, 0, u1, 1'b0, wr, rd, nop_follow, 1'b0);
    endtask

    initial begin
        int hz;
        checks   = 0;
        errors   = 0;
        m_stall  = 0;
        m_bubble = 0;
        reset    = 1'b1;
        bus.dec_valid = 1'b0; bus.dec_is_branch = 1'b0; bus.dec_rs1 = '0; bus.dec_rs2 = '0;
        bus.dec_uses_rs1 = 1'b0; bus.dec_uses_rs2 = 1'b0; bus.dec_writes_rd = 1'b0;
        bus.dec_rd = '0; bus.nop_step_3 = 1'b0;
        @(posedge clk);

        // Reset held two cycles with a live decode.
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
        idle(1'b0);
        check("rst_nop_step_5", d_nop5, 1);
        check("rst_step_4", d_step4, 0);
        check("rst_stall_cnt", d_stall, 0);
        check("rst_bubble_cnt", d_bubble, 0);

        // RAW stall on r5 with the bench feeding the hazard back as a bubble request.
        idle(1'b1);
        issue(1'b0, 1'b1, 5, 0, 1'b0, 1'b0);
        hz = 0;
        for (int i = 0; i < 10; i++) begin
            issue(1'b0, 1'b0, 0, 5, 1'b1, 1'b1);
            if (d_haz == 0) break;
            hz++;
        end
        check("raw_cycles", hz, 3);
        idle(1'b0);
        check("raw_stall_cnt", d_stall, 3);
        check("raw_bubble_cnt", d_bubble, 3);

        // Writes to r0 never hazard.
        idle(1'b1);
        issue(1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
            check("r0_hazard", d_haz, 0);
        end
        idle(1'b0);
        check("r0_stall_cnt", d_stall, 0);

        // Branch walks decode -> execute -> memory -> writeback.
        idle(1'b1);
        issue(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        check("br_c1", d_br, 1);
        check("br_c1_s4", d_step4, 0);
        idle(1'b0);
        check("br_c2", d_br, 1);
        check("br_c2_s4", d_step4, 0);
        idle(1'b0);
        check("br_c3", d_br, 1);
        check("br_c3_s4", d_step4, 1);
        idle(1'b0);
        check("br_c4", d_br, 0);
        check("br_c4_nop5", d_nop5, 0);

        // A self-dependent writer of r7 keeps the hazard up every cycle to saturate stall_cnt.
        idle(1'b1);
        issue(1'b0, 1'b1, 7, 0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) issue(1'b0, 1'b1, 7, 7, 1'b1, 1'b0);
        idle(1'b0);
        check("sat_stall_cnt", d_stall, CMAX);
        idle(1'b0);
        check("sat_stall_hold", d_stall, CMAX);

        // Mid-stream reset with a branch in execute and a writer of r9 in memory.
        idle(1'b1);
        issue(1'b0, 1'b1, 9, 0, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 9, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 0, 9, 1'b1, 1'b0);
        check("mid_hazard", d_haz, 0);
        check("mid_branch", d_br, 0);
        check("mid_stall_cnt", d_stall, 0);
        check("mid_bubble_cnt", d_bubble, 0);

        // Randomized traffic over a small register window so dependencies are frequent.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
